nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit additions on a shared 4-bit ripple adder, one nibble per clock, least significant nibble first. The carry is chained between nibbles in an internal register. The adder sits outside this block as a combinational slice. This block drives its operand and carry inputs and captures its sum and carry outputs. A start/busy/done handshake faces the requester.

---
 rtl/nibble_serial_add_ctrl.sv | 143 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer driving an external 4-bit ripple slice, LS nibble first.
// Optional subtract support is enabled by defining SUB_EN (adds the sub port).
module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              last_slice;

    assign last_slice = (idx_q == IDXW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_slice) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        unique case (state_q)
            StRun: begin
                busy    = 1'b1;
                add_a   = a_q[3:0];
                add_b   = b_q[3:0];
                add_cin = carry_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d   = op_a;
                    idx_d = '0;
`ifdef SUB_EN
                    // Two's complement subtract: invert B once here, force the carry-in.
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = op_b;
                    carry_d = cin;
`endif
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDXW'(i)) acc_d[4*i +: 4] = add_s;
                end
                carry_d = add_cout;
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                idx_d   = idx_q + IDXW'(1);
                if (last_slice) begin
                    sum_d  = acc_d;
                    cout_d = add_cout;
                    idx_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl with a behavioural 4-bit adder slice.
// Subtract scenarios are exercised only when SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // External combinational slice.
    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib(input logic [W-1:0] v, input int i);
        logic [W-1:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    // Carry entering nibble i of a + be + ce.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] be,
                                        input logic ce, input int i);
        logic [W:0] m;
        logic [W:0] t;
        m = ((W+1)'(1) << (4 * i)) - (W+1)'(1);
        t = ({1'b0, a} & m) + ({1'b0, be} & m) + (W+1)'(ce);
        return t[4 * i];
    endfunction

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0
            || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b add_a=%h add_b=%h add_cin=%b, required all 0",
                     name, busy, done, add_a, add_b, add_cin);
        end
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            errors++;
            $display("FAIL %s: sum=%h cout=%b, required sum=%h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input logic hammer, input string name);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   r;
        be = s ? ~b : b;
        ce = s ? 1'b1 : c;
        r  = {1'b0, a} + {1'b0, be} + (W+1)'(ce);
        op_a  = a;
        op_b  = b;
        cin   = c;
`ifdef SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < N; i++) begin
            if (hammer) begin
                start = 1'b1;
                op_a  = 16'hAAAA;
                op_b  = 16'h5555;
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s run%0d busy/done: busy=%b done=%b, required 1/0",
                         name, i, busy, done);
            end
            checks++;
            if (add_a !== nib(a, i) || add_b !== nib(be, i)
                || add_cin !== carry_into(a, be, ce, i)) begin
                errors++;
                $display("FAIL %s run%0d slice: a=%h b=%h cin=%b, required a=%h b=%h cin=%b",
                         name, i, add_a, add_b, add_cin, nib(a, i), nib(be, i),
                         carry_into(a, be, ce, i));
            end
            checks++;
            if (sum !== exp_sum || cout !== exp_cout) begin
                errors++;
                $display("FAIL %s run%0d hold: sum=%h cout=%b, required sum=%h cout=%b",
                         name, i, sum, cout, exp_sum, exp_cout);
            end
            step();
        end
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse: done=%b busy=%b, required 1/0", name, done, busy);
        end
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b, required sum=%h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
        step();
        start = 1'b0;
        check_idle_outputs({name, " after done"});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
`ifdef SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) step();
        exp_sum  = '0;
        exp_cout = 1'b0;
        check_idle_outputs("reset held");
        rst_n = 1'b1;
        repeat (3) step();
        check_idle_outputs("reset released");
    endtask

    task automatic test_basic();
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_carry_chain();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "carry ffff+1");
        run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, "carry 00ff+cin");
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_busy_protect();
        run_op(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1, "busy hammer");
        run_op(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0, "start after done");
    endtask

    task automatic test_reset_mid_run();
        op_a  = 16'h9999;
        op_b  = 16'h8888;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        check_idle_outputs("mid-run reset");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            step();
            check_idle_outputs("post-reset quiet");
        end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, "post-reset add");
    endtask

`ifdef SUB_EN
    task automatic test_sub();
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, "sub 7-5");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, "sub 5-7");
        run_op(16'h1234, 16'h0002, 1'b0, 1'b1, 1'b0, "sub b=2");
        for (int k = 0; k < 10; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, "sub random");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_random();
        test_busy_protect();
        test_reset_mid_run();
`ifdef SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
